pixel_mem_ctrl: RTL and testbench
=================================

Name: pixel_mem_ctrl

Overview:
- Sequencer for the CNN1 pixel local memory, which is 3 channels × 32×32 × 16-bit, 1-cycle synchronous read, with separate write and read ports.
- LOAD phase: accepts a valid/ready stream of 16-bit pixels and writes them in channel-major raster order.
- SWEEP phase: issues 3×3 window reads in raster order and returns 48-bit {B,G,R} taps through a 2-entry output FIFO with backpressure.
- Sits between the bus-side input DMA and the conv PE array.

Parameters:
- IMG_DIM, 32, image width/height; power of 2, ≤32 (row/col fields are 5 bits).
- KSIZE, 3, window size; taps per window = KSIZE*KSIZE.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- start  in  1  1-cycle pulse; begins LOAD when IDLE, ignored otherwise
- in_valid  in  1  pixel stream valid
- in_ready  out  1  pixel stream ready
- in_data  in  16  pixel word
- write_pixel_signal  out  1  memory write strobe
- write_pixel_addr  out  16  {4'b0, ch[1:0], row[4:0], col[4:0]}
- write_pixel_data  out  16  pixel to memory
- read_pixel_signal  out  1  memory read strobe
- read_pixel_addr  out  16  {6'b0, row[4:0], col[4:0]}
- read_pixel_data  in  48  {ch2, ch1, ch0}, valid one cycle after read_pixel_signal
- win_valid  out  1  FIFO head valid
- win_ready  in  1  consumer accepts head
- win_data  out  48  tap pixel
- win_tap  out  4  tap index 0..KSIZE²-1, kr*KSIZE+kc
- win_row  out  5  window origin row
- win_col  out  5  window origin col
- win_last  out  1  last tap of last window
- busy  out  1  high in LOAD/SWEEP/DRAIN
- done  out  1  1-cycle pulse on return to IDLE

Behaviour:
- Reset: state=IDLE; all counters 0; FIFO empty.
  - All outputs 0: in_ready, write/read strobes, addresses, data, win_*, busy, done.
- States: IDLE → LOAD → SWEEP → DRAIN → IDLE.
- IDLE: start=1 → LOAD next cycle, busy=1.
- LOAD:
  - in_ready=1 combinationally.
  - write_pixel_signal = in_valid & in_ready; write address/data driven combinationally from the counters and in_data.
  - Counter order: col fastest, then row, then ch (0..2).
  - After accepting word (ch=2, row=col=IMG_DIM-1) → SWEEP; total CH*IMG_DIM² = 3072 writes.
- SWEEP:
  - Origin (r,c) iterates 0..IMG_DIM-KSIZE (30×30 windows); taps kr,kc 0..KSIZE-1, kc fastest.
  - Read address = (r+kr)*IMG_DIM + (c+kc).
  - Issue condition: fifo_count + pending < 2, where pending = read issued last cycle.
  - Full throughput is one tap/cycle when win_ready=1.
  - Tag {tap,row,col,last} is registered with the issue; data + tag enter the FIFO the next cycle.
  - After the final tap is issued → DRAIN.
  - read_pixel_signal=0 whenever not issuing.
- DRAIN: wait until pending=0 and FIFO empty, then IDLE with done=1 for one cycle.
- FIFO:
  - 2 entries; push and pop in the same cycle are allowed when non-empty.
  - Pop = win_valid & win_ready.
  - win_* show the head; hold stable while win_valid & !win_ready.
  - Overflow is impossible by the credit rule.
- Total windows = 900 × 9 taps = 8100 FIFO pops; win_last=1 only on (r=29, c=29, tap=8).
- start while busy: ignored, no effect on counters.
- Reset mid-operation: immediate return to IDLE with reset values; memory contents are not cleared.

Optional Feature:
- Macro PIXEL_CTRL_PAD_EN.
- Defined: "same" zero padding.
  - Origins iterate 0..IMG_DIM-1 (32×32 windows); tap position = origin + k - KSIZE/2.
  - Out-of-range taps issue no memory read; they push 48'd0 through the same pipeline slot (pending tagged as zero-fill) so ordering and credits are unchanged.
  - Totals become 1024 windows × 9 = 9216 pops; win_last on (31, 31, tap 8).
- Undefined: valid-only sweep as described in Behaviour.

Test Plan:
- Reset, then start; stream 3072 words in_data=i with in_valid=1 → writes at addresses 0x000..0x3FF (ch0), 0x400..0x7FF (ch1), 0x800..0xBFF (ch2); data matches; SWEEP entered next cycle.
- Memory model returns {addr,addr,addr}; win_ready=1 → first taps at read addresses 0, 1, 2, 32, 33, 34, 64, 65, 66.
  - Window (0,1) starts at address 1.
  - 8100 pops, one per cycle after the 1-cycle latency; win_last on pop 8100; done pulses once; busy=0 after.
- win_ready toggled randomly 50% → no tap lost or duplicated.
  - Order matches the reference sequence.
  - fifo_count never >2; win_data stable while stalled.
- in_valid gapped (1 of every 3 cycles) → exactly 3072 writes, write_pixel_signal only on accepted cycles; start pulsed mid-LOAD → ignored.
- rst=0 asserted at LOAD word 1500 and again mid-SWEEP → outputs zero asynchronously.
  - Next start restarts at address 0, ch0.
- With PIXEL_CTRL_PAD_EN: window (0,0) taps 0-3 and 6 are 0 with no reads issued; tap 4 reads address 0; 9216 pops; win_last at (31,31).

Source files
------------

// File: rtl/pixel_mem_ctrl_if.sv
// pixel_mem_ctrl_if
//   Bundles every handshake and bus signal of the pixel memory sequencer.
//   master : the sequencer side (pixel_mem_ctrl)
//   slave  : the environment side (input DMA, pixel memory, PE array)
//   Groups: control (start/busy/done), pixel input stream (in_*),
//           memory write port (write_pixel_*), memory read port (read_pixel_*),
//           window tap stream (win_*).
interface pixel_mem_ctrl_if;
    logic        start;
    logic        busy;
    logic        done;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;

    logic        write_pixel_signal;
    logic [15:0] write_pixel_addr;
    logic [15:0] write_pixel_data;

    logic        read_pixel_signal;
    logic [15:0] read_pixel_addr;
    logic [47:0] read_pixel_data;

    logic        win_valid;
    logic        win_ready;
    logic [47:0] win_data;
    logic [3:0]  win_tap;
    logic [4:0]  win_row;
    logic [4:0]  win_col;
    logic        win_last;

    modport master (
        input  start, in_valid, in_data, read_pixel_data, win_ready,
        output busy, done, in_ready,
               write_pixel_signal, write_pixel_addr, write_pixel_data,
               read_pixel_signal, read_pixel_addr,
               win_valid, win_data, win_tap, win_row, win_col, win_last
    );

    modport slave (
        output start, in_valid, in_data, read_pixel_data, win_ready,
        input  busy, done, in_ready,
               write_pixel_signal, write_pixel_addr, write_pixel_data,
               read_pixel_signal, read_pixel_addr,
               win_valid, win_data, win_tap, win_row, win_col, win_last
    );
endinterface

// File: rtl/pixel_mem_ctrl.sv
// pixel_mem_ctrl
//   Sequencer for the CNN1 pixel local memory (3 ch x IMG_DIM x IMG_DIM x 16b,
//   1-cycle synchronous read). LOAD writes a pixel stream in channel-major
//   raster order; SWEEP reads KSIZE x KSIZE windows in raster order and hands
//   {B,G,R} taps to the PE array through a 2-entry FIFO with backpressure.
// Ports
//   clk : clock, rising edge
//   rst : asynchronous reset, active low
//   bus : pixel_mem_ctrl_if.master (control, pixel stream, memory write/read
//         ports, window tap stream)
// Build option
//   PIXEL_CTRL_PAD_EN : "same" zero padding; origins cover the whole image and
//                       out-of-image taps are zero-filled without a memory read.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | accepting pixel stream, one memory write per accepted word
// S_SWEEP | issuing window tap reads under FIFO credit control
// S_DRAIN | all taps issued, waiting for last read and FIFO to empty
module pixel_mem_ctrl #(
    parameter int IMG_DIM = 32,
    parameter int KSIZE   = 3
) (
    input  logic             clk,
    input  logic             rst,
    pixel_mem_ctrl_if.master bus
);
    localparam int CH_LAST = 2;
    localparam int DLAST   = IMG_DIM - 1;
    localparam int KLAST   = KSIZE - 1;
`ifdef PIXEL_CTRL_PAD_EN
    localparam int ORG_LAST = IMG_DIM - 1;
    localparam int PAD_OFS  = KSIZE / 2;
`else
    localparam int ORG_LAST = IMG_DIM - KSIZE;
    localparam int PAD_OFS  = 0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DRAIN} state_t;
    state_t r_state, w_state_nxt;

    logic [1:0]  r_ld_ch;
    logic [4:0]  r_ld_row, r_ld_col;
    logic [4:0]  r_org_r, r_org_c;
    logic [3:0]  r_kr, r_kc;

    logic        r_pend, r_pend_zero;
    logic [14:0] r_tag;          // {tap, row, col, last} of the read in flight
    logic [62:0] r_fifo [2];     // {data, tap, row, col, last}
    logic        r_wr_ptr, r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_done;

    logic        w_wr, w_ld_last, w_pop, w_issue, w_in_range, w_tap_last;
    logic        w_kc_wrap, w_kr_wrap, w_c_wrap;
    logic [7:0]  w_pos_r, w_pos_c;
    logic [3:0]  w_tap;
    logic [47:0] w_push_data;
    logic [62:0] w_head;

    assign w_wr      = (r_state == S_LOAD) && bus.in_valid;
    assign w_ld_last = (r_ld_ch == 2'(CH_LAST)) && (r_ld_row == 5'(DLAST)) && (r_ld_col == 5'(DLAST));

    assign w_kc_wrap  = (r_kc == 4'(KLAST));
    assign w_kr_wrap  = (r_kr == 4'(KLAST));
    assign w_c_wrap   = (r_org_c == 5'(ORG_LAST));
    assign w_tap_last = w_kc_wrap && w_kr_wrap && w_c_wrap && (r_org_r == 5'(ORG_LAST));
    assign w_tap      = r_kr * 4'(KSIZE) + r_kc;

    // Tap position may fall outside the image when padding is enabled; a
    // negative position wraps to a large unsigned value and fails the range test.
    assign w_pos_r    = {3'b0, r_org_r} + {4'b0, r_kr} - 8'(PAD_OFS);
    assign w_pos_c    = {3'b0, r_org_c} + {4'b0, r_kc} - 8'(PAD_OFS);
    assign w_in_range = (w_pos_r < 8'(IMG_DIM)) && (w_pos_c < 8'(IMG_DIM));

    // Credit check counts the slot freed by this cycle's pop, so a steady
    // win_ready=1 consumer sees one tap per cycle without ever exceeding 2.
    assign w_pop   = (r_count != 2'd0) && bus.win_ready;
    assign w_issue = (r_state == S_SWEEP) &&
                     (({1'b0, r_count} + {2'b0, r_pend} - {2'b0, w_pop}) < 3'd2);

    assign w_push_data = r_pend_zero ? 48'd0 : bus.read_pixel_data;
    assign w_head      = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (w_wr && w_ld_last) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: if (w_issue && w_tap_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_pend && (r_count == 2'd0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_ch     <= '0;
            r_ld_row    <= '0;
            r_ld_col    <= '0;
            r_org_r     <= '0;
            r_org_c     <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_pend      <= 1'b0;
            r_pend_zero <= 1'b0;
            r_tag       <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
            r_done      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_ld_ch  <= '0;
                r_ld_row <= '0;
                r_ld_col <= '0;
                r_org_r  <= '0;
                r_org_c  <= '0;
                r_kr     <= '0;
                r_kc     <= '0;
            end
            if (w_wr) begin
                if (r_ld_col == 5'(DLAST)) begin
                    r_ld_col <= '0;
                    if (r_ld_row == 5'(DLAST)) begin
                        r_ld_row <= '0;
                        r_ld_ch  <= (r_ld_ch == 2'(CH_LAST)) ? 2'd0 : r_ld_ch + 2'd1;
                    end else begin
                        r_ld_row <= r_ld_row + 5'd1;
                    end
                end else begin
                    r_ld_col <= r_ld_col + 5'd1;
                end
            end
            if (w_issue) begin
                r_tag <= {w_tap, r_org_r, r_org_c, w_tap_last};
                if (!w_kc_wrap) begin
                    r_kc <= r_kc + 4'd1;
                end else begin
                    r_kc <= '0;
                    if (!w_kr_wrap) begin
                        r_kr <= r_kr + 4'd1;
                    end else begin
                        r_kr <= '0;
                        if (!w_c_wrap) begin
                            r_org_c <= r_org_c + 5'd1;
                        end else begin
                            r_org_c <= '0;
                            r_org_r <= (r_org_r == 5'(ORG_LAST)) ? 5'd0 : r_org_r + 5'd1;
                        end
                    end
                end
            end
            r_pend      <= w_issue;
            r_pend_zero <= w_issue && !w_in_range;
            if (r_pend) begin
                r_fifo[r_wr_ptr] <= {w_push_data, r_tag};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
            r_done  <= (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
        end
    end

    assign bus.done               = r_done;
    assign bus.write_pixel_signal = w_wr;
    assign bus.write_pixel_addr   = (r_state == S_LOAD) ? {4'b0, r_ld_ch, r_ld_row, r_ld_col} : 16'd0;
    assign bus.write_pixel_data   = (r_state == S_LOAD) ? bus.in_data : 16'd0;
    assign bus.read_pixel_signal  = w_issue && w_in_range;
    assign bus.read_pixel_addr    = bus.read_pixel_signal ? {6'b0, w_pos_r[4:0], w_pos_c[4:0]} : 16'd0;

    assign bus.win_valid = (r_count != 2'd0);
    assign bus.win_data  = bus.win_valid ? w_head[62:15] : 48'd0;
    assign bus.win_tap   = bus.win_valid ? w_head[14:11] : 4'd0;
    assign bus.win_row   = bus.win_valid ? w_head[10:6]  : 5'd0;
    assign bus.win_col   = bus.win_valid ? w_head[5:1]   : 5'd0;
    assign bus.win_last  = bus.win_valid && w_head[0];
endmodule

// File: tb/tb_pixel_mem_ctrl.sv
module tb_pixel_mem_ctrl;
    localparam int IMG    = 32;
    localparam int K      = 3;
    localparam int KK     = K * K;
    localparam int NWORDS = 3 * IMG * IMG;
`ifdef PIXEL_CTRL_PAD_EN
    localparam int NW  = IMG;
    localparam int OFS = K / 2;
`else
    localparam int NW  = IMG - K + 1;
    localparam int OFS = 0;
`endif
    localparam int NTAPS        = NW * NW * KK;
    localparam int SWEEP_BUDGET = 3 * NTAPS + 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_mem_ctrl_if bus ();
    pixel_mem_ctrl #(.IMG_DIM(IMG), .KSIZE(K)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int checks = 0;
    int errors = 0;

    logic [15:0] img [0:NWORDS-1];
    logic [15:0] mem [0:NWORDS-1];

    // Pixel memory: write port plus 1-cycle synchronous read of all 3 channels.
    always @(posedge clk) begin
        if (bus.write_pixel_signal && (int'(bus.write_pixel_addr) < NWORDS))
            mem[int'(bus.write_pixel_addr)] <= bus.write_pixel_data;
        if (bus.read_pixel_signal)
            bus.read_pixel_data <= {mem[2048 + int'(bus.read_pixel_addr[9:0])],
                                    mem[1024 + int'(bus.read_pixel_addr[9:0])],
                                    mem[int'(bus.read_pixel_addr[9:0])]};
    end

    typedef struct packed {
        logic [47:0] data;
        logic [3:0]  tap;
        logic [4:0]  row;
        logic [4:0]  col;
        logic        last;
    } tap_t;

    typedef struct {
        logic        start;
        logic        in_valid;
        logic [15:0] in_data;
        logic        exp_ready;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic        exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: pop p is tap p%9 of window p/9, windows in raster order.
    function automatic int tap_pr(int p);
        return ((p / KK) / NW) + (p % KK) / K - OFS;
    endfunction
    function automatic int tap_pc(int p);
        return ((p / KK) % NW) + (p % KK) % K - OFS;
    endfunction
    function automatic bit tap_in_range(int p);
        return tap_pr(p) >= 0 && tap_pr(p) < IMG && tap_pc(p) >= 0 && tap_pc(p) < IMG;
    endfunction
    function automatic tap_t ref_tap(int p);
        tap_t e;
        int   a;
        a      = tap_pr(p) * IMG + tap_pc(p);
        e.tap  = 4'(p % KK);
        e.row  = 5'((p / KK) / NW);
        e.col  = 5'((p / KK) % NW);
        e.last = (p == NTAPS - 1);
        e.data = tap_in_range(p) ? {img[2 * IMG * IMG + a], img[IMG * IMG + a], img[a]} : 48'd0;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({bus.in_ready, bus.write_pixel_signal, bus.read_pixel_signal,
                                 bus.win_valid, bus.win_last, bus.busy, bus.done}), 64'd0);
        check({tag, "_addr"}, 64'({bus.write_pixel_addr, bus.write_pixel_data, bus.read_pixel_addr}), 64'd0);
        check({tag, "_wdata"}, 64'(bus.win_data), 64'd0);
        check({tag, "_wtag"}, 64'({bus.win_tap, bus.win_row, bus.win_col}), 64'd0);
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // mode 0: in_valid always, 1: one of every three cycles, 2: random
    task automatic do_load(input int k0, input int mode, input int stop_at, input bit poke_start);
        int  k   = k0;
        int  cyc = 0;
        logic v;
        while (k < stop_at && cyc < 20000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = v ? img[k] : 16'($urandom);
            bus.start    = poke_start && (cyc == 100);
            @(negedge clk);
            check("ld_ready", 64'(bus.in_ready), 64'd1);
            check("ld_wr_strobe", 64'(bus.write_pixel_signal), 64'(v));
            if (v) begin
                check("ld_wr_addr", 64'(bus.write_pixel_addr), 64'(k));
                check("ld_wr_data", 64'(bus.write_pixel_data), 64'(img[k]));
            end
            @(posedge clk); #1;
            if (v) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("ld_word_count", 64'(k), 64'(stop_at));
    endtask

    // mode 0: win_ready held high, 1: win_ready random 50%
    task automatic do_sweep(input int mode, input int stop_pops, input bit post_load);
        int   p = 0, q = 0, cyc = 0, nreads = 0, exp_reads = 0, dn = 0;
        int   first_pop = -1, last_pop = -1;
        bit   stalled = 1'b0;
        logic [62:0] held = '0;
        logic [62:0] cur;
        tap_t e;
        while (p < stop_pops && cyc < SWEEP_BUDGET) begin
            bus.win_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_valid  = post_load && (cyc == 0);
            @(negedge clk);
            if (post_load && cyc == 0) begin
                check("sweep_entry_ready", 64'(bus.in_ready), 64'd0);
                check("sweep_entry_wr", 64'(bus.write_pixel_signal), 64'd0);
                check("sweep_entry_busy", 64'(bus.busy), 64'd1);
            end
            if (bus.read_pixel_signal) begin
                while (q < NTAPS && !tap_in_range(q)) q++;
                check("rd_addr", 64'(bus.read_pixel_addr),
                      (q < NTAPS) ? 64'(tap_pr(q) * IMG + tap_pc(q)) : 64'hDEAD_0000);
                q++;
                nreads++;
            end
            cur = {bus.win_data, bus.win_tap, bus.win_row, bus.win_col, bus.win_last};
            if (stalled) begin
                check("stall_valid", 64'(bus.win_valid), 64'd1);
                check("stall_hold", 64'(cur), 64'(held));
            end
            stalled = 1'b0;
            if (bus.win_valid) begin
                if (bus.win_ready) begin
                    e = ref_tap(p);
                    check("win_data", 64'(bus.win_data), 64'(e.data));
                    check("win_tap", 64'(bus.win_tap), 64'(e.tap));
                    check("win_row", 64'(bus.win_row), 64'(e.row));
                    check("win_col", 64'(bus.win_col), 64'(e.col));
                    check("win_last", 64'(bus.win_last), 64'(e.last));
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    p++;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("sweep_pop_count", 64'(p), 64'(stop_pops));
        if (stop_pops == NTAPS) begin
            if (mode == 0) check("sweep_throughput", 64'(last_pop - first_pop), 64'(NTAPS - 1));
            for (int i = 0; i < NTAPS; i++) if (tap_in_range(i)) exp_reads++;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus.done) dn++;
                if (bus.read_pixel_signal) nreads++;
                @(posedge clk); #1;
            end
            check("read_count", 64'(nreads), 64'(exp_reads));
            check("done_pulses", 64'(dn), 64'd1);
            check("busy_after", 64'(bus.busy), 64'd0);
            check("fifo_empty_after", 64'(bus.win_valid), 64'd0);
        end
        bus.win_ready = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.win_ready = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'd0;

        // IDLE ignores in_valid; start enters LOAD; start during LOAD is ignored.
        vecs[0] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 16'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 16'd9, 1'b1, 1'b0, 16'd0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 16'd1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 16'd2, 1'b1, 1'b1, 16'd2, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 16'd3, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Run 1: in_data = word index, continuous stream, consumer always ready.
        for (int i = 0; i < NWORDS; i++) img[i] = 16'(i);
        for (int i = 0; i < 7; i++) begin
            bus.start    = vecs[i].start;
            bus.in_valid = vecs[i].in_valid;
            bus.in_data  = vecs[i].in_data;
            @(negedge clk);
            check("vec_ready", 64'(bus.in_ready), 64'(vecs[i].exp_ready));
            check("vec_wr", 64'(bus.write_pixel_signal), 64'(vecs[i].exp_wr));
            check("vec_busy", 64'(bus.busy), 64'(vecs[i].exp_busy));
            if (vecs[i].exp_wr) begin
                check("vec_addr", 64'(bus.write_pixel_addr), 64'(vecs[i].exp_addr));
                check("vec_data", 64'(bus.write_pixel_data), 64'(vecs[i].in_data));
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        do_load(4, 0, NWORDS, 1'b0);
        do_sweep(0, NTAPS, 1'b1);

        // Run 2: random pixels, gapped stream with a stray start, random backpressure.
        for (int i = 0; i < NWORDS; i++) img[i] = 16'($urandom);
        start_pulse();
        do_load(0, 1, NWORDS, 1'b1);
        do_sweep(1, NTAPS, 1'b1);

        // Reset during LOAD at word 1500.
        for (int i = 0; i < NWORDS; i++) img[i] = 16'($urandom);
        start_pulse();
        do_load(0, 2, 1500, 1'b0);
        rst = 1'b0;
        #1;
        check_zero("rst_mid_load");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Restart from word 0, then reset during SWEEP.
        start_pulse();
        do_load(0, 0, NWORDS, 1'b0);
        do_sweep(1, 500, 1'b1);
        rst = 1'b0;
        #1;
        check_zero("rst_mid_sweep");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        start_pulse();
        do_load(0, 0, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
